coherent_memory_control: RTL and testbench



---
 rtl/coherent_memory_control_if.sv | 50 +++++
 rtl/coherent_memory_control.sv | 182 ++++++++++++++++++
 tb/tb_coherent_memory_control.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/coherent_memory_control_if.sv
// Cache-control bus between both CPUs' caches, the RAM port and
// the coherent memory controller.
interface coherent_memory_control_if #(
   parameter int CPUS = 2
);
   logic [CPUS-1:0]       iREN;
   logic [CPUS-1:0]       dREN;
   logic [CPUS-1:0]       dWEN;
   logic [CPUS-1:0][31:0] iaddr;
   logic [CPUS-1:0][31:0] daddr;
   logic [CPUS-1:0][31:0] dstore;
   logic [CPUS-1:0]       ccwrite;
   logic [CPUS-1:0]       cctrans;
   logic [CPUS-1:0]       halt;
   logic [31:0]           ramload;
   logic [1:0]            ramstate;
   logic [CPUS-1:0]       iwait;
   logic [CPUS-1:0]       dwait;
   logic [CPUS-1:0][31:0] iload;
   logic [CPUS-1:0][31:0] dload;
   logic                  ramREN;
   logic                  ramWEN;
   logic [31:0]           ramaddr;
   logic [31:0]           ramstore;
   logic [CPUS-1:0]       ccwait;
   logic [CPUS-1:0]       ccinv;
   logic [CPUS-1:0][31:0] ccsnoopaddr;

   modport master (
      input  iREN, dREN, dWEN,
      input  iaddr, daddr, dstore,
      input  ccwrite, cctrans, halt,
      input  ramload, ramstate,
      output iwait, dwait, iload, dload,
      output ramREN, ramWEN,
      output ramaddr, ramstore,
      output ccwait, ccinv, ccsnoopaddr
   );

   modport slave (
      output iREN, dREN, dWEN,
      output iaddr, daddr, dstore,
      output ccwrite, cctrans, halt,
      output ramload, ramstate,
      input  iwait, dwait, iload, dload,
      input  ramREN, ramWEN,
      input  ramaddr, ramstore,
      input  ccwait, ccinv, ccsnoopaddr
   );
endinterface

// File: rtl/coherent_memory_control.sv
// Dual-core MSI bus controller: arbitrates icache/dcache traffic
// onto one RAM port and forwards Modified lines cache-to-cache.
module coherent_memory_control (
   input logic                 CLK,
   input logic                 RST,
   coherent_memory_control_if.master bus
);
   typedef enum logic [3:0] {
      IDLE, IFETCH, WB0, WB1, SNOOP,
      C2C0, C2C1, LOAD0, LOAD1
   } state_t;

   localparam logic [1:0] ACCESS = 2'b10;

   state_t state;
   logic   g;
   logic   p;
   logic   inv_q;
   // favoured CPU per class; flips only on completion
   logic   fav_w;
   logic   fav_r;
   logic   fav_i;
   logic   acc;
   logic   live;
   logic   done;
   logic   unused;

   logic [1:0]       iwait;
   logic [1:0]       dwait;
   logic [1:0][31:0] iload;
   logic [1:0][31:0] dload;
   logic [1:0]       ccwait;
   logic [1:0]       ccinv;
   logic [1:0][31:0] snoop;
   logic             ren;
   logic             wen;
   logic [31:0]      addr;
   logic [31:0]      store;

   function automatic logic pick(
      input logic [1:0] req,
      input logic       fav
   );
      return req[fav] ? fav : ~fav;
   endfunction

   assign p      = ~g;
   assign acc    = bus.ramstate == ACCESS;
   assign unused = ^bus.halt;

   always_comb begin
      live = 1'b0;
      unique case (state)
         IDLE:     live = 1'b0;
         IFETCH:   live = bus.iREN[g];
         WB0, WB1: live = bus.dWEN[g];
         default:  live = bus.dREN[g];
      endcase
      live = live & ~RST;
   end

   assign done = live & acc &
      (state inside {IFETCH, WB1, C2C1, LOAD1});

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         g     <= 1'b0;
         inv_q <= 1'b0;
         fav_w <= 1'b0;
         fav_r <= 1'b0;
         fav_i <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|bus.dWEN) begin
                  g     <= pick(bus.dWEN, fav_w);
                  state <= WB0;
               end else if (|bus.dREN) begin
                  g     <= pick(bus.dREN, fav_r);
                  state <= SNOOP;
               end else if (|bus.iREN) begin
                  g     <= pick(bus.iREN, fav_i);
                  state <= IFETCH;
               end
            end
            SNOOP: begin
               inv_q <= bus.ccwrite[g] & bus.cctrans[g];
               if (!live)          state <= IDLE;
               else if (bus.dWEN[p]) state <= C2C0;
               else                state <= LOAD0;
            end
            default: begin
               if (!live) state <= IDLE;
               else if (acc) begin
                  unique case (state)
                     WB0:     state <= WB1;
                     C2C0:    state <= C2C1;
                     LOAD0:   state <= LOAD1;
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
         if (done) begin
            if (state == IFETCH)   fav_i <= p;
            else if (state == WB1) fav_w <= p;
            else                   fav_r <= p;
         end
      end
   end

   always_comb begin
      iwait  = '1;
      dwait  = '1;
      iload  = '0;
      dload  = '0;
      ccwait = '0;
      ccinv  = '0;
      snoop  = '0;
      ren    = 1'b0;
      wen    = 1'b0;
      addr   = '0;
      store  = '0;
      if (live) begin
         unique case (state)
            IFETCH: begin
               ren  = 1'b1;
               addr = bus.iaddr[g];
               if (acc) begin
                  iwait[g] = 1'b0;
                  iload[g] = bus.ramload;
               end
            end
            WB0, WB1: begin
               wen   = 1'b1;
               addr  = bus.daddr[g];
               store = bus.dstore[g];
               if (acc) dwait[g] = 1'b0;
            end
            C2C0, C2C1: begin
               wen   = 1'b1;
               addr  = bus.daddr[p];
               store = bus.dstore[p];
               if (acc) begin
                  dwait    = '0;
                  dload[g] = bus.dstore[p];
               end
            end
            LOAD0, LOAD1: begin
               ren  = 1'b1;
               addr = bus.daddr[g];
               if (acc) begin
                  dwait[g] = 1'b0;
                  dload[g] = bus.ramload;
               end
            end
            default: ;
         endcase
         if (state inside {SNOOP, C2C0, C2C1, LOAD0, LOAD1}) begin
            ccwait[p] = 1'b1;
            snoop[p]  = bus.daddr[g];
            // snoop cycle samples live intent; later beats use the latch
            ccinv[p]  = (state == SNOOP)
                      ? bus.ccwrite[g] & bus.cctrans[g]
                      : inv_q;
         end
      end
   end

   assign bus.iwait       = iwait;
   assign bus.dwait       = dwait;
   assign bus.iload       = iload;
   assign bus.dload       = dload;
   assign bus.ccwait      = ccwait;
   assign bus.ccinv       = ccinv;
   assign bus.ccsnoopaddr = snoop;
   assign bus.ramREN      = ren;
   assign bus.ramWEN      = wen;
   assign bus.ramaddr     = addr;
   assign bus.ramstore    = store;
endmodule

// File: tb/tb_coherent_memory_control.sv
// Directed bench for the coherent memory controller; RAM data
// is modelled as {16'hC0DE, ramaddr[15:0]}.
module tb_coherent_memory_control;
   logic CLK;
   logic RST;
   int   nvec;
   int   nerr;

   localparam logic [1:0] FREE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] ACCESS = 2'b10;

   coherent_memory_control_if bus ();

   coherent_memory_control dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   assign bus.ramload = {16'hC0DE, bus.ramaddr[15:0]};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      RST = 1'b1;
      bus.iREN = '0;
      bus.dREN = '0;
      bus.dWEN = '0;
      bus.iaddr = '0;
      bus.daddr = '0;
      bus.dstore = '0;
      bus.ccwrite = '0;
      bus.cctrans = '0;
      bus.halt = '0;
      bus.ramstate = FREE;
      tick;
      settle;
      chk("rst_iwait", 64'(bus.iwait), 64'h3);
      chk("rst_dwait", 64'(bus.dwait), 64'h3);
      chk("rst_strb", {bus.ramREN, bus.ramWEN}, 0);
      tick;
      RST = 1'b0;
      bus.ramstate = ACCESS;
      settle;
      chk("idle_addr", {bus.ramaddr, bus.ramstore}, 0);
      chk("idle_cc", {bus.ccwait, bus.ccinv}, 0);
      chk("idle_snp", 64'(bus.ccsnoopaddr), 0);
      chk("idle_ld", 64'(bus.iload) | 64'(bus.dload), 0);

      // 1: both icaches fetch; CPU0 first, then CPU1
      bus.iREN = 2'b11;
      bus.iaddr[0] = 32'h40;
      bus.iaddr[1] = 32'h80;
      settle;
      chk("t1_idle_ren", 64'(bus.ramREN), 0);
      tick;
      chk("t1_ren0", 64'(bus.ramREN), 1);
      chk("t1_addr0", 64'(bus.ramaddr), 64'h40);
      chk("t1_iwait0", 64'(bus.iwait), 64'h2);
      chk("t1_iload0", 64'(bus.iload[0]), 64'hC0DE0040);
      tick;
      bus.iREN = 2'b10;
      settle;
      chk("t1_gap", {bus.iwait, bus.ramREN}, 64'h6);
      tick;
      chk("t1_addr1", 64'(bus.ramaddr), 64'h80);
      chk("t1_iwait1", 64'(bus.iwait), 64'h1);
      chk("t1_iload", 64'(bus.iload), 64'hC0DE0080_00000000);
      tick;
      bus.iREN = '0;

      // 2: data beats instruction
      bus.dREN = 2'b01;
      bus.daddr[0] = 32'h100;
      bus.iREN = 2'b10;
      settle;
      tick;
      chk("t2_ccwait", 64'(bus.ccwait), 64'h2);
      chk("t2_snpa", 64'(bus.ccsnoopaddr[1]), 64'h100);
      chk("t2_snp_inv", {bus.ccinv, bus.ramREN}, 0);
      chk("t2_snp_dw", 64'(bus.dwait), 64'h3);
      tick;
      chk("t2_l0_addr", 64'(bus.ramaddr), 64'h100);
      chk("t2_l0_dw", 64'(bus.dwait), 64'h2);
      chk("t2_l0_dl", 64'(bus.dload[0]), 64'hC0DE0100);
      chk("t2_l0_cc", 64'(bus.ccwait), 64'h2);
      tick;
      bus.daddr[0] = 32'h104;
      settle;
      chk("t2_l1_addr", 64'(bus.ramaddr), 64'h104);
      chk("t2_l1_dl", 64'(bus.dload[0]), 64'hC0DE0104);
      tick;
      bus.dREN = '0;
      settle;
      chk("t2_idle", {bus.ccwait, bus.ramREN}, 0);
      tick;
      chk("t2_if_w", 64'(bus.iwait), 64'h1);
      chk("t2_if_a", 64'(bus.ramaddr), 64'h80);
      tick;
      bus.iREN = '0;

      // 3: BusRdX against a Modified peer -> cache-to-cache
      bus.dREN = 2'b01;
      bus.ccwrite = 2'b01;
      bus.cctrans = 2'b01;
      bus.daddr[0] = 32'h200;
      tick;
      bus.dWEN = 2'b10;
      bus.daddr[1] = 32'h200;
      bus.dstore[1] = 32'hDEADBEEF;
      settle;
      chk("t3_inv", {bus.ccinv, bus.ccwait}, 64'hA);
      tick;
      chk("t3_wen", {bus.ramWEN, bus.ramREN}, 64'h2);
      chk("t3_addr", 64'(bus.ramaddr), 64'h200);
      chk("t3_store", 64'(bus.ramstore), 64'hDEADBEEF);
      chk("t3_dload", 64'(bus.dload[0]), 64'hDEADBEEF);
      chk("t3_dwait", 64'(bus.dwait), 0);
      tick;
      bus.daddr[0] = 32'h204;
      bus.daddr[1] = 32'h204;
      bus.dstore[1] = 32'hCAFEF00D;
      settle;
      chk("t3_c1_addr", 64'(bus.ramaddr), 64'h204);
      chk("t3_c1_dl", 64'(bus.dload[0]), 64'hCAFEF00D);
      chk("t3_c1_inv", {bus.ccinv, bus.dwait}, 64'h8);
      tick;
      bus.dREN = '0;
      bus.dWEN = '0;
      bus.ccwrite = '0;
      bus.cctrans = '0;
      settle;
      chk("t3_idle", {bus.ccinv, bus.ramWEN, bus.dwait}, 64'h3);

      // 4: write-back with three BUSY cycles per beat
      bus.dWEN = 2'b10;
      bus.daddr[1] = 32'h300;
      bus.dstore[1] = 32'h11112222;
      bus.ramstate = BUSY;
      tick;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 3; i++) begin
            settle;
            chk("t4_busy", {bus.ramWEN, bus.dwait}, 64'h7);
            tick;
         end
         bus.ramstate = ACCESS;
         settle;
         chk("t4_acc_dw", 64'(bus.dwait), 64'h1);
         chk("t4_acc_a", 64'(bus.ramaddr), 64'(32'h300 + 4 * b));
         chk("t4_acc_s", 64'(bus.ramstore), 64'h11112222);
         tick;
         bus.daddr[1] = 32'h304;
         bus.ramstate = BUSY;
      end
      bus.dWEN = '0;
      bus.ramstate = ACCESS;
      settle;
      chk("t4_idle", {bus.ramWEN, bus.dwait}, 64'h3);

      // 5: reset in LOAD1, then a fresh fill
      bus.dREN = 2'b10;
      bus.daddr[1] = 32'h400;
      tick;
      chk("t5_snp", 64'(bus.ccsnoopaddr[0]), 64'h400);
      tick;
      chk("t5_l0", 64'(bus.dwait), 64'h1);
      tick;
      bus.daddr[1] = 32'h404;
      RST = 1'b1;
      settle;
      chk("t5_rst_now", {bus.ramREN, bus.dwait}, 64'h3);
      tick;
      RST = 1'b0;
      bus.dREN = 2'b11;
      bus.daddr[0] = 32'h500;
      settle;
      chk("t5_after", {bus.ccwait, bus.ramREN, bus.dwait}, 64'h3);
      tick;
      chk("t5_grant0", 64'(bus.ccwait), 64'h2);
      chk("t5_snpa", 64'(bus.ccsnoopaddr[1]), 64'h500);
      tick;
      chk("t5_l0_dl", 64'(bus.dload[0]), 64'hC0DE0500);
      chk("t5_l0_dw", 64'(bus.dwait), 64'h2);
      tick;
      bus.daddr[0] = 32'h504;
      settle;
      chk("t5_l1_a", 64'(bus.ramaddr), 64'h504);
      tick;
      bus.dREN = '0;

      // 6: requester abandons fill during LOAD0
      bus.dREN = 2'b01;
      bus.daddr[0] = 32'h600;
      tick;
      tick;
      bus.ramstate = BUSY;
      settle;
      chk("t6_busy", {bus.ramREN, bus.dwait}, 64'h7);
      chk("t6_dl0", 64'(bus.dload), 0);
      bus.dREN = '0;
      settle;
      chk("t6_drop_dw", 64'(bus.dwait), 64'h3);
      tick;
      bus.ramstate = ACCESS;
      settle;
      chk("t6_idle", {bus.ccwait, bus.ramREN, bus.dwait}, 64'h3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
